rng_wb_reader: RTL and testbench

Wishbone classic responder that turns the free-running chaotic RNG outputs into software-readable random words. It samples one of the `rng_chaos` state words (or their XOR) at a programmable rate into a small FIFO and serves control, status and data registers to the management SoC over the user-area Wishbone port. It sits in the user project wrapper between `rng_chaos` and the `wbs_*` bus, and drives one IRQ line.

---
 rtl/rng_wb_pkg.sv | 36 +++
 rtl/rng_sample_fifo.sv | 56 +++++
 rtl/rng_wb_reader.sv | 137 +++++++++++++
 tb/tb_rng_wb_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_wb_pkg.sv
// rtl/rng_wb_pkg.sv - register map, bit positions and source select for rng_wb_reader
package rng_wb_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DATA   = 4'h8;
  localparam logic [3:0] OFF_THRESH = 4'hC;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_SRC_LSB   = 2;
  localparam int CTRL_DIV_LSB   = 8;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 8;
  localparam int STAT_LEVEL_LSB = 16;

  typedef enum logic [1:0] {
    SRC_X   = 2'd0,
    SRC_Y   = 2'd1,
    SRC_Z   = 2'd2,
    SRC_XOR = 2'd3
  } rng_src_e;

  function automatic logic [31:0] rng_select(input rng_src_e src, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] z);
    case (src)
      SRC_X:   return x;
      SRC_Y:   return y;
      SRC_Z:   return z;
      default: return x ^ y ^ z;
    endcase
  endfunction

endpackage

// File: rtl/rng_sample_fifo.sv
// rtl/rng_sample_fifo.sv - power-of-two sample FIFO with flush and occupancy level
module rng_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same edge, so a push into a full FIFO is still accepted.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];
  assign level   = count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wptr] <= din;
  end

endmodule

// File: rtl/rng_wb_reader.sv
// rtl/rng_wb_reader.sv - Wishbone classic responder sampling RNG state words into a readable FIFO
module rng_wb_reader
  import rng_wb_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [31:0] rng_x_i,
  input  logic [31:0] rng_y_i,
  input  logic [31:0] rng_z_i,
  output logic        irq_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          en;
  rng_src_e      src;
  logic [7:0]    div;
  logic [6:0]    thresh;
  logic          ovf;
  logic [7:0]    cnt;

  logic          hit;
  logic          req;
  logic          wr;
  logic          rd;
  logic [3:0]    off;
  logic          flush;
  logic          fifo_push;
  logic          fifo_pop;
  logic [31:0]   fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic [LW-1:0] level;
  logic [31:0]   sample;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign unused_bits = ^{wbs_dat_i[31:16], wbs_dat_i[7], wbs_adr_i[1:0]};

  assign hit   = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req   = wbs_cyc_i && wbs_stb_i && hit && !wbs_ack_o;
  assign wr    = req && wbs_we_i;
  assign rd    = req && !wbs_we_i;
  assign off   = {wbs_adr_i[3:2], 2'b00};
  assign flush = wr && (off == OFF_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_FLUSH_BIT];

  assign fifo_pop  = rd && (off == OFF_DATA) && !fifo_empty;
  assign fifo_push = en && (cnt == div);
  assign sample    = rng_select(src, rng_x_i, rng_y_i, rng_z_i);

  rng_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .flush  (flush),
    .din    (sample),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .level  (level)
  );

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL: begin
        rdata[CTRL_EN_BIT]           = en;
        rdata[CTRL_SRC_LSB +: 2]     = src;
        rdata[CTRL_DIV_LSB +: 8]     = div;
      end
      OFF_STATUS: begin
        rdata[STAT_EMPTY_BIT]        = fifo_empty;
        rdata[STAT_FULL_BIT]         = fifo_full;
        rdata[STAT_OVF_BIT]          = ovf;
        rdata[STAT_LEVEL_LSB +: LW]  = level;
      end
      OFF_DATA:   rdata = fifo_empty ? '0 : fifo_dout;
      OFF_THRESH: rdata[6:0] = thresh;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      en        <= 1'b0;
      src       <= SRC_X;
      div       <= '0;
      thresh    <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      irq_o     <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : '0;

      // Counter reloads on every push, so the push cadence is DIV+1 cycles.
      if (flush || !en || fifo_push) cnt <= '0;
      else                           cnt <= cnt + 8'd1;

      if (wr && (off == OFF_CTRL)) begin
        if (wbs_sel_i[0]) begin
          en  <= wbs_dat_i[CTRL_EN_BIT];
          src <= rng_src_e'(wbs_dat_i[CTRL_SRC_LSB +: 2]);
        end
        if (wbs_sel_i[1]) div <= wbs_dat_i[CTRL_DIV_LSB +: 8];
      end

      if (wr && (off == OFF_THRESH) && wbs_sel_i[0]) thresh <= wbs_dat_i[6:0];

      // A drop in the same cycle as a clear keeps OVF set so the event is not lost.
      if (fifo_push && fifo_full && !fifo_pop && !flush)
        ovf <= 1'b1;
      else if (wr && (off == OFF_STATUS) && wbs_sel_i[1] && wbs_dat_i[STAT_OVF_BIT])
        ovf <= 1'b0;

      irq_o <= (thresh != '0) && (7'(level) >= thresh);
    end
  end

endmodule

// File: tb/tb_rng_wb_reader.sv
// tb/tb_rng_wb_reader.sv - directed and randomized checks of rng_wb_reader against a queue model
module tb_rng_wb_reader;
  import rng_wb_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_ni, cyc, stb, we, ack, irq;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat_o, x, y, z;
  bit          rnd_rng = 0;
  bit          chk_on = 0;

  always #5 clk = ~clk;

  rng_wb_reader #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
    .rng_x_i(x), .rng_y_i(y), .rng_z_i(z), .irq_o(irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, sampler as "enabled cycles since restart" modulo DIV+1.
  logic [31:0] q[$];
  logic        m_ovf, m_en;
  logic [1:0]  m_src;
  logic [7:0]  m_div;
  logic [6:0]  m_thr;
  int          run;
  logic        e_ack, e_irq;
  logic [31:0] e_dat;

  always @(posedge clk) begin : model
    logic        req, push, pop, flush;
    logic [1:0]  o;
    logic [31:0] rv, word;
    int          lvl;
    lvl = q.size();
    if (!rst_ni) begin
      q.delete();
      m_ovf = 0; m_en = 0; m_src = 0; m_div = 0; m_thr = 0; run = 0;
      e_ack = 0; e_dat = 0; e_irq = 0;
    end else begin
      req = cyc && stb && (adr[31:4] == BASE[31:4]) && !e_ack;
      o = adr[3:2];
      rv = 0;
      pop = 0;
      if (req && !we) begin
        case (o)
          2'd0: rv = {16'd0, m_div, 4'd0, m_src, 1'b0, m_en};
          2'd1: begin
            rv[22:16] = 7'(lvl);
            rv[8] = m_ovf;
            rv[1] = (lvl == DEPTH);
            rv[0] = (lvl == 0);
          end
          2'd2: begin
            rv = (lvl != 0) ? q[0] : 32'd0;
            pop = (lvl != 0);
          end
          default: rv = {25'd0, m_thr};
        endcase
      end
      push = m_en && ((run % (m_div + 1)) == m_div);
      case (m_src)
        2'd0: word = x;
        2'd1: word = y;
        2'd2: word = z;
        default: word = x ^ y ^ z;
      endcase
      flush = req && we && (o == 2'd0) && sel[0] && wdat[1];
      e_irq = (m_thr != 0) && (lvl >= m_thr);
      if (req && we && (o == 2'd1) && sel[1] && wdat[8]) m_ovf = 0;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          if (q.size() < DEPTH) q.push_back(word);
          else m_ovf = 1;
        end
      end
      run = (flush || !m_en) ? 0 : run + 1;
      if (req && we && (o == 2'd0)) begin
        if (sel[0]) begin m_en = wdat[0]; m_src = wdat[3:2]; end
        if (sel[1]) m_div = wdat[15:8];
      end
      if (req && we && (o == 2'd3) && sel[0]) m_thr = wdat[6:0];
      e_ack = req;
      e_dat = (req && !we) ? rv : 32'd0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("ack", {31'd0, ack}, {31'd0, e_ack});
      check("rdata", rdat_o, e_dat);
      check("irq", {31'd0, irq}, {31'd0, e_irq});
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_rng) begin x = $urandom; y = $urandom; z = $urandom; end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic xfer(input logic w, input logic [3:0] o, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] r);
    int n = 0;
    cyc = 1; stb = 1; we = w; sel = s; adr = BASE | {28'd0, o}; wdat = d;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    if (!ack) check("bus_ack_timeout", {31'd0, ack}, 32'd1);
    r = rdat_o;
    cyc = 0; stb = 0; we = 0; sel = 0;
  endtask

  task automatic wr(input logic [3:0] o, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] r;
    xfer(1'b1, o, s, d, r);
  endtask

  task automatic rd(input logic [3:0] o, output logic [31:0] r);
    xfer(1'b0, o, 4'hF, 32'd0, r);
  endtask

  initial begin
    logic [31:0] r, cfg;
    int n;
    rst_ni = 0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    x = 0; y = 0; z = 0;
    repeat (3) @(posedge clk);
    #1; rst_ni = 1; chk_on = 1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", rdat_o, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    rd(OFF_STATUS, r); check("t1_status", r, 32'h0000_0001);
    rd(OFF_DATA, r);   check("t1_data_empty", r, 32'h0);
    rd(OFF_STATUS, r); check("t1_status_after", r, 32'h0000_0001);

    x = 32'h1234_5678;
    wr(OFF_CTRL, 4'hF, 32'h1);
    idle(2);
    wr(OFF_CTRL, 4'hF, 32'h0);
    rd(OFF_STATUS, r); check("t2_level3", r, 32'h0003_0000);
    for (int i = 0; i < 3; i++) begin
      rd(OFF_DATA, r); check("t2_data", r, 32'h1234_5678);
    end
    rd(OFF_STATUS, r); check("t2_empty", r, 32'h0000_0001);

    x = 32'hFF00_FF00; y = 32'h0F0F_0F0F; z = 32'h0000_FFFF;
    wr(OFF_CTRL, 4'hF, 32'h0000_040D);
    idle(8);
    wr(OFF_CTRL, 4'hF, 32'h0000_040C);
    rd(OFF_STATUS, r); check("t3_one_push", r, 32'h0001_0000);
    rd(OFF_DATA, r);   check("t3_xor", r, 32'hF00F_0FF0);
    wr(OFF_CTRL, 4'hF, 32'h0000_040D);
    idle(9);
    wr(OFF_CTRL, 4'hF, 32'h0000_040C);
    rd(OFF_STATUS, r); check("t3_two_push", r, 32'h0002_0000);
    rd(OFF_DATA, r);   check("t3_xor_a", r, 32'hF00F_0FF0);
    rd(OFF_DATA, r);   check("t3_xor_b", r, 32'hF00F_0FF0);

    x = 32'h1111_1111;
    wr(OFF_CTRL, 4'hF, 32'h1);
    idle(1);
    x = 32'h2222_2222;
    idle(11);
    rd(OFF_STATUS, r); check("t4_full_ovf", r, 32'h0008_0102);
    wr(OFF_CTRL, 4'hF, 32'h0);
    rd(OFF_STATUS, r); check("t4_full_hold", r, 32'h0008_0102);
    rd(OFF_DATA, r);   check("t4_first_kept", r, 32'h1111_1111);
    wr(OFF_STATUS, 4'hF, 32'h0000_0100);
    rd(OFF_STATUS, r); check("t4_ovf_clr", r, 32'h0007_0000);
    wr(OFF_CTRL, 4'hF, 32'h2);
    rd(OFF_STATUS, r); check("t4_flush", r, 32'h0000_0001);

    wr(OFF_THRESH, 4'hF, 32'h4);
    wr(OFF_CTRL, 4'hF, 32'h1);
    idle(3);
    wr(OFF_CTRL, 4'hF, 32'h0);
    check("t5_irq_low", {31'd0, irq}, 32'd0);
    idle(1);
    check("t5_irq_rise", {31'd0, irq}, 32'd1);
    rd(OFF_DATA, r);   check("t5_data", r, 32'h2222_2222);
    check("t5_irq_hold", {31'd0, irq}, 32'd1);
    idle(1);
    check("t5_irq_fall", {31'd0, irq}, 32'd0);
    rd(OFF_STATUS, r); check("t5_level3", r, 32'h0003_0000);

    wr(OFF_CTRL, 4'hF, 32'h0000_000C);
    wr(OFF_CTRL, 4'b0010, 32'h0000_05FF);
    rd(OFF_CTRL, r);   check("t6_sel_div", r, 32'h0000_050C);
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = BASE + 32'h10;
    n = 0;
    repeat (6) begin @(posedge clk); #1; if (ack) n++; end
    check("t6_no_ack_out_of_range", n, 0);
    cyc = 0; stb = 0;

    wr(OFF_CTRL, 4'hF, 32'h1);
    wr(OFF_CTRL, 4'hF, 32'h0);
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = BASE | 32'h8; rst_ni = 0;
    idle(1);
    check("t7_rst_no_ack", {31'd0, ack}, 32'd0);
    cyc = 0; stb = 0;
    idle(1);
    check("t7_rst_no_ack2", {31'd0, ack}, 32'd0);
    rst_ni = 1;
    rd(OFF_STATUS, r); check("t7_status", r, 32'h0000_0001);
    rd(OFF_CTRL, r);   check("t7_ctrl", r, 32'h0);

    cfg = 32'h0;
    rnd_rng = 1;
    repeat (250) begin
      case ($urandom_range(0, 10))
        0, 1, 2: rd(OFF_DATA, r);
        3: rd(OFF_STATUS, r);
        4: rd(OFF_CTRL, r);
        5: begin
          r = $urandom; r[6:0] = 7'($urandom_range(0, 9));
          wr(OFF_THRESH, 4'($urandom), r);
        end
        6: wr(OFF_STATUS, 4'($urandom), $urandom);
        7: begin
          wr(OFF_CTRL, 4'hF, 32'h0);
          cfg = {16'd0, 8'($urandom_range(0, 5)), 4'd0, 2'($urandom), 1'b0, 1'($urandom)};
          wr(OFF_CTRL, 4'hF, cfg);
        end
        8: wr(OFF_CTRL, 4'b0011, cfg | 32'h2);
        9: wr(OFF_DATA, 4'hF, $urandom);
        default: idle($urandom_range(1, 6));
      endcase
    end
    rnd_rng = 0;
    idle(2);
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
